// File: rtl/swap_sequencer.sv
// -----------------------------------------------------------------------------
// swap_sequencer
//
// This block exchanges a pair of registers under control. It loads a pair of
// WIDTH-bit values. It then exchanges the two registers once per clock, for a
// programmed number of cycles. It reports how many exchanges ran, and whether
// the final pair is reversed relative to the loaded pair.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   load      in   capture a_in/b_in into a/b (IDLE only)
//   a_in      in   [WIDTH-1:0] value loaded into a
//   b_in      in   [WIDTH-1:0] value loaded into b
//   start     in   begin a run (IDLE only)
//   count     in   [CNT_W-1:0] number of swaps, sampled with start
//   a         out  [WIDTH-1:0] register A
//   b         out  [WIDTH-1:0] register B
//   busy      out  high while the run is executing (RUN state)
//   done      out  one-cycle pulse when a run completes (DONE state)
//   swaps     out  [CNT_W-1:0] swaps performed in the current/last run
//   swapped   out  1 when a/b hold the reverse of the loaded pair
//   dbg_state out  [1:0] current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Handshake: the block accepts start/load on a rising edge only while it is
// IDLE (busy=0, done=0). After it accepts start, busy stays high for exactly
// 'count' cycles. done then pulses for one cycle, and the block returns to
// IDLE. The block drops start/load in RUN and DONE. It does not queue them.
// busy and done are decodes of the state register, so both are never high at
// the same time.
// -----------------------------------------------------------------------------
module swap_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] swaps,
  output logic             swapped,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] swaps_q, swaps_d;
  logic             swapped_q, swapped_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    swaps_d     = swaps_q;
    swapped_d   = swapped_q;
    remaining_d = remaining_q;

    unique case (state_q)
      IDLE: begin
        // When load and start arrive in the same cycle, the block accepts
        // both. The freshly loaded pair is the starting pair, and the first
        // exchange happens on the following edge.
        if (load) begin
          a_d       = a_in;
          b_d       = b_in;
          swapped_d = 1'b0;
        end
        if (start) begin
          swaps_d     = CNT_ZERO;
          remaining_d = count;
          state_d     = (count != CNT_ZERO) ? RUN : DONE;
        end
      end

      RUN: begin
        // Both registers update on the same edge from each other's current
        // value. This is the nonblocking exchange, so no temporary is needed.
        a_d         = b_q;
        b_d         = a_q;
        swapped_d   = ~swapped_q;
        swaps_d     = swaps_q + CNT_ONE;
        remaining_d = remaining_q - CNT_ONE;
        if (remaining_q == CNT_ONE) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      swaps_q     <= '0;
      swapped_q   <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      swaps_q     <= swaps_d;
      swapped_q   <= swapped_d;
      remaining_q <= remaining_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign a         = a_q;
  assign b         = b_q;
  assign swaps     = swaps_q;
  assign swapped   = swapped_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_swap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_swap_sequencer
//
// Self-checking bench for swap_sequencer.
//
// For each run, the bench pushes the expected final outcome into exp_q. It
// computes that outcome from the run rules: an odd count leaves the pair
// reversed, and an even count leaves it unchanged.
//
// A monitor process does the rest:
//   - it pops and compares an entry from exp_q on every done pulse;
//   - it checks that each busy cycle swapped a and b;
//   - it checks that busy and done are never high together.
// -----------------------------------------------------------------------------
module tb_swap_sequencer;

  localparam int W     = 8;
  localparam int C     = 8;
  localparam int EXP_W = 2*W + 2*C + 1;   // {a, b, swaps, swapped, busy_cycles}

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  always #5 clk = ~clk;

  logic         load = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         start = 1'b0;
  logic [C-1:0] count = '0;
  logic [W-1:0] a, b;
  logic         busy, done, swapped;
  logic [C-1:0] swaps;
  logic [1:0]   dbg_state;

  swap_sequencer #(.WIDTH(W), .CNT_W(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .a_in      (a_in),
    .b_in      (b_in),
    .start     (start),
    .count     (count),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .swaps     (swaps),
    .swapped   (swapped),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [EXP_W-1:0] exp_q[$];

  // Reference model: what the registers should hold while the block is idle.
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic         m_sw = 1'b0;
  logic [C-1:0] m_swaps = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  int           busy_run  = 0;
  logic         prev_busy = 1'b0;
  logic         prev_done = 1'b0;
  logic [W-1:0] prev_a    = '0;
  logic [W-1:0] prev_b    = '0;

  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (!reset) begin
      busy_run  = 0;
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (busy && done) chk("busy_done_exclusive", 1, 0);
      if (prev_busy) begin
        chk("swap_edge_a", a, prev_b);
        chk("swap_edge_b", b, prev_a);
      end
      if (done) begin
        done_cnt++;
        if (prev_done) chk("done_single_pulse", 1, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("final_a",       a,        e[2*C+2*W : 2*C+W+1]);
          chk("final_b",       b,        e[2*C+W : 2*C+1]);
          chk("final_swaps",   swaps,    e[2*C : C+1]);
          chk("final_swapped", swapped,  e[C]);
          chk("busy_cycles",   busy_run, e[C-1:0]);
        end
        busy_run = 0;
      end
      if (busy) busy_run++;
      prev_busy = busy;
      prev_done = done;
      prev_a    = a;
      prev_b    = b;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_load(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    load = 1'b1; a_in = x; b_in = y;
    @(negedge clk);
    load = 1'b0;
    m_a = x; m_b = y; m_sw = 1'b0;
  endtask

  // Issues one run of n swaps, optionally loading a new pair in the same
  // cycle. If inject is set, it pulses load and start mid-run; the DUT must
  // ignore both.
  task automatic run(input int n, input logic with_load,
                     input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic inject);
    logic [W-1:0] fa, fb;
    logic         fsw;
    logic [C-1:0] nc;
    int           target;
    nc = n[C-1:0];
    @(negedge clk);
    start = 1'b1; count = nc;
    if (with_load) begin
      load = 1'b1; a_in = x; b_in = y;
      m_a = x; m_b = y; m_sw = 1'b0;
    end
    fa  = nc[0] ? m_b : m_a;
    fb  = nc[0] ? m_a : m_b;
    fsw = m_sw ^ nc[0];
    exp_q.push_back({fa, fb, nc, fsw, nc});
    target = done_cnt + 1;
    @(negedge clk);
    start = 1'b0; load = 1'b0;
    count = C'($urandom_range(0, 255));
    #1;
    for (int i = 0; i < n + 10 && done_cnt < target; i++) begin
      if (inject && i == 2) begin
        load = 1'b1; a_in = 8'd77; start = 1'b1; count = 8'd2;
      end else if (inject && i == 3) begin
        load = 1'b0; start = 1'b0;
      end
      @(negedge clk); #1;
    end
    load = 1'b0; start = 1'b0;
    if (done_cnt < target) begin
      chk("done_timeout", 0, 1);
      exp_q.delete();
    end
    m_a = fa; m_b = fb; m_sw = fsw; m_swaps = nc;
  endtask

  // After a run, the block must stay idle and hold its results.
  task automatic idle_hold_check();
    repeat (3) begin
      @(negedge clk); #1;
      chk("idle_busy",  busy,  0);
      chk("idle_hold_a", a,    m_a);
      chk("idle_hold_b", b,    m_b);
      chk("idle_swaps", swaps, m_swaps);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset held low while the clock runs.
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_swaps", swaps, 0);
    chk("rst_swapped", swapped, 0);
    chk("rst_state", dbg_state, 0);
    @(negedge clk);
    reset = 1'b1;

    // Single swap.
    do_load(8'd18, 8'd0);
    run(1, 1'b0, 0, 0, 1'b0);
    idle_hold_check();

    // Even run.
    do_load(8'd18, 8'd0);
    run(4, 1'b0, 0, 0, 1'b0);

    // Zero count with simultaneous load and start.
    run(0, 1'b1, 8'd5, 8'd9, 1'b0);
    idle_hold_check();

    // Load/start pulsed mid-run are ignored.
    do_load(8'h11, 8'h22);
    run(6, 1'b0, 0, 0, 1'b1);
    idle_hold_check();

    // Restart without reloading after an odd run: swapped carries over.
    do_load(8'h3C, 8'hC3);
    run(3, 1'b0, 0, 0, 1'b0);
    run(5, 1'b0, 0, 0, 1'b0);

    // Maximum count: swaps reaches 255 without wrapping.
    do_load(8'hAA, 8'h55);
    run(255, 1'b0, 0, 0, 1'b0);

    // Reset asserted mid-run, between clock edges.
    do_load(8'hA5, 8'h3C);
    @(negedge clk);
    start = 1'b1; count = 8'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_swaps", swaps, 3);
    chk("mid_a", a, 8'h3C);
    reset = 1'b0;
    #1;
    chk("async_a", a, 0);
    chk("async_b", b, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_swaps", swaps, 0);
    chk("async_swapped", swapped, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_a = '0; m_b = '0; m_sw = 1'b0; m_swaps = '0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("post_rst_no_done", done, 0);
    end
    run(3, 1'b1, 8'h12, 8'h34, 1'b0);

    // Randomized runs.
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 1) == 1) do_load(W'($urandom), W'($urandom));
      run($urandom_range(0, 20), 1'($urandom_range(0, 1)),
          W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end
    idle_hold_check();

    chk("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
